bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using double dabble, one shift per clock.
- Sits directly upstream of the hex-display seg7 drivers; each 4-bit BCD digit output feeds one seg7 instance so values show in decimal on the HEX displays.
- Converts a WIDTH-bit unsigned value on a start/ready handshake.
- Holds the result steady between conversions.

---
 rtl/bin2bcd_pkg.sv | 17 +
 rtl/bcd_add3.sv | 11 +
 rtl/bin2bcd_seq.sv | 130 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: adds 3 to a BCD digit of 5 or more.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= BCD_DIGIT_W'(5)) ? (i_digit + BCD_DIGIT_W'(3)) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Optional leading-zero blanking output is enabled with BIN2BCD_BLANK_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin_in,
    output logic                          ready,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          ovf,
`ifdef BIN2BCD_BLANK_EN
    output logic [DIGITS-1:0]             blank,
`endif
    output state_t                        dbg_state
);

    localparam int CW = cnt_width(WIDTH);
    localparam int SW = BCD_DIGIT_W * DIGITS;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_bin;
    logic [SW-1:0]    r_scratch;
    logic [SW-1:0]    r_bcd;
    logic             r_sovf;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic [SW-1:0]    w_adj;
    logic             w_cnt_zero;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // SHIFT spends one extra cycle at count zero to publish the result.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_cnt_zero) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == IDLE);
        done  = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin     <= '0;
            r_scratch <= '0;
            r_sovf    <= 1'b0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin     <= bin_in;
                        r_scratch <= '0;
                        r_sovf    <= 1'b0;
                        r_cnt     <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    if (!w_cnt_zero) begin
                        r_scratch <= {w_adj[SW-2:0], r_bin[WIDTH-1]};
                        r_bin     <= {r_bin[WIDTH-2:0], 1'b0};
                        r_sovf    <= r_sovf | w_adj[SW-1];
                        r_cnt     <= r_cnt - 1'b1;
                    end else begin
                        r_bcd <= r_scratch;
                        r_ovf <= r_sovf;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] w_blank;
    logic [DIGITS-1:0] r_blank;

    // A digit blanks only when it and every more significant digit are zero.
    always_comb begin
        logic v_hi_zero;
        v_hi_zero = 1'b1;
        w_blank   = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_hi_zero  = v_hi_zero & (r_scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            w_blank[i] = v_hi_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_blank <= {{(DIGITS-1){1'b1}}, 1'b0};
        else if (r_state == SHIFT && w_cnt_zero)
            r_blank <= w_blank;
    end

    assign blank = r_blank;
`endif

    assign bcd_out   = r_bcd;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed scoreboard bench for bin2bcd_seq: a 4-digit and a 3-digit instance.
module tb_bin2bcd_seq;
    import bin2bcd_pkg::*;

    localparam int W  = 10;
    localparam int EW = 22; // {chk_bcd, blank[3:0], ovf, bcd[15:0]}

    logic          clk = 1'b0;
    logic          rst;
    logic          s4, s3;
    logic [W-1:0]  b4, b3;
    logic          rdy4, dn4, ov4, rdy3, dn3, ov3;
    logic [15:0]   bcd4;
    logic [11:0]   bcd3;
    state_t        st4, st3;
`ifdef BIN2BCD_BLANK_EN
    logic [3:0]    blk4;
    logic [2:0]    blk3;
`endif

    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [EW-1:0] exp4_q[$];
    logic [EW-1:0] exp3_q[$];
    int            cyc4_q[$];
    int            cyc3_q[$];
    logic [15:0]   hold4 = '0;
    logic          chk_rdy4 = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.WIDTH(W), .DIGITS(4)) u_dut4 (
        .clk(clk), .reset(rst), .start(s4), .bin_in(b4),
        .ready(rdy4), .done(dn4), .bcd_out(bcd4), .ovf(ov4),
`ifdef BIN2BCD_BLANK_EN
        .blank(blk4),
`endif
        .dbg_state(st4)
    );

    bin2bcd_seq #(.WIDTH(W), .DIGITS(3)) u_dut3 (
        .clk(clk), .reset(rst), .start(s3), .bin_in(b3),
        .ready(rdy3), .done(dn3), .bcd_out(bcd3), .ovf(ov3),
`ifdef BIN2BCD_BLANK_EN
        .blank(blk3),
`endif
        .dbg_state(st3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [15:0] bcd, input logic o,
                                         input logic [3:0] blk, input logic chk);
        return {chk, blk, o, bcd};
    endfunction

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int c;
        if (rst) begin
            exp4_q.delete();
            cyc4_q.delete();
            hold4    = '0;
            chk_rdy4 = 1'b0;
        end else begin
            if (chk_rdy4) begin
                check("ready_after_done4", rdy4, 1);
                chk_rdy4 = 1'b0;
            end
            if (dn4) begin
                if (exp4_q.size() == 0) begin
                    check("unexpected_done4", 1, 0);
                end else begin
                    e = exp4_q.pop_front();
                    c = cyc4_q.pop_front();
                    check("bcd4", bcd4, e[15:0]);
                    check("ovf4", ov4, e[16]);
                    check("latency4", cyc, c);
                    check("ready_in_done4", rdy4, 0);
`ifdef BIN2BCD_BLANK_EN
                    check("blank4", blk4, e[20:17]);
`endif
                    hold4    = e[15:0];
                    chk_rdy4 = 1'b1;
                end
            end else begin
                check("hold4", bcd4, hold4);
            end
        end
    end

    always @(negedge clk) begin
        logic [EW-1:0] e;
        int c;
        if (rst) begin
            exp3_q.delete();
            cyc3_q.delete();
        end else if (dn3) begin
            if (exp3_q.size() == 0) begin
                check("unexpected_done3", 1, 0);
            end else begin
                e = exp3_q.pop_front();
                c = cyc3_q.pop_front();
                check("ovf3", ov3, e[16]);
                check("latency3", cyc, c);
                if (e[21]) begin
                    check("bcd3", bcd3, e[11:0]);
`ifdef BIN2BCD_BLANK_EN
                    check("blank3", blk3, e[19:17]);
`endif
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept(input int sel, input logic [W-1:0] v, input logic [EW-1:0] e,
                          input bit push);
        int t = 0;
        while (((sel == 4) ? rdy4 : rdy3) !== 1'b1 && t < 100) begin
            tick(1);
            t++;
        end
        if (t >= 100) check("ready_timeout", 0, 1);
        if (sel == 4) begin s4 = 1'b1; b4 = v; end
        else          begin s3 = 1'b1; b3 = v; end
        tick(1);
        if (sel == 4) begin
            s4 = 1'b0;
            b4 = $urandom_range(0, 1023);
            if (push) begin exp4_q.push_back(e); cyc4_q.push_back(cyc + W + 1); end
        end else begin
            s3 = 1'b0;
            b3 = $urandom_range(0, 1023);
            if (push) begin exp3_q.push_back(e); cyc3_q.push_back(cyc + W + 1); end
        end
    endtask

    task automatic wait_idle(input int sel);
        int t = 0;
        while (((sel == 4) ? exp4_q.size() : exp3_q.size()) != 0 && t < 100) begin
            tick(1);
            t++;
        end
        if (t >= 100) check("done_timeout", 0, 1);
        tick(2);
    endtask

    task automatic convert(input int sel, input logic [W-1:0] v, input logic [EW-1:0] e);
        accept(sel, v, e, 1'b1);
        wait_idle(sel);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        s4 = 1'b0; s3 = 1'b0; b4 = '0; b3 = '0;
        tick(3);
        rst = 1'b0;

        check("rst_ready4", rdy4, 1);
        check("rst_done4", dn4, 0);
        check("rst_bcd4", bcd4, 0);
        check("rst_ovf4", ov4, 0);
        check("rst_state4", st4, IDLE);
        check("rst_ready3", rdy3, 1);
        check("rst_bcd3", bcd3, 0);
`ifdef BIN2BCD_BLANK_EN
        check("rst_blank4", blk4, 4'b1110);
        check("rst_blank3", blk3, 3'b110);
`endif

        convert(4, 10'd1023, mk(16'h1023, 1'b0, 4'b0000, 1'b1));
        convert(4, 10'd0,    mk(16'h0000, 1'b0, 4'b1110, 1'b1));
        convert(4, 10'd9,    mk(16'h0009, 1'b0, 4'b1110, 1'b1));
        convert(4, 10'd10,   mk(16'h0010, 1'b0, 4'b1100, 1'b1));
        convert(4, 10'd1000, mk(16'h1000, 1'b0, 4'b0000, 1'b1));

        // start while busy must be ignored
        accept(4, 10'd500, mk(16'h0500, 1'b0, 4'b1000, 1'b1), 1'b1);
        tick(1);
        check("busy_ready4", rdy4, 0);
        s4 = 1'b1; b4 = 10'd7;
        tick(1);
        s4 = 1'b0;
        wait_idle(4);
        tick(W + 4);

        // reset five cycles into a conversion aborts it
        accept(4, 10'd999, '0, 1'b0);
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("abort_ready4", rdy4, 1);
        check("abort_bcd4", bcd4, 0);
        check("abort_state4", st4, IDLE);
        tick(W + 4);
        convert(4, 10'd42, mk(16'h0042, 1'b0, 4'b1100, 1'b1));

        // three-digit instance: overflow then in-range
        convert(3, 10'd1000, mk(16'h0000, 1'b1, 4'b0000, 1'b0));
        convert(3, 10'd999,  mk(16'h0999, 1'b0, 4'b0000, 1'b1));

        check("queue4_empty", exp4_q.size(), 0);
        check("queue3_empty", exp3_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
